// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches, and buffers
// in-order responses in a small circular queue feeding decode.
module stage_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   input  logic        stall,
   output logic        fetch_valid,
   output logic [31:0] instr,
   output logic [31:0] fetch_instr_addr,
   output logic [31:0] fetch_instr_addr_plus
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]            pc;
   logic [31:0]            q_addr [QUEUE_DEPTH];
   logic [31:0]            q_data [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] q_filled;
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       pend_cnt;
   logic [CNT_W-1:0]       discard_cnt;

   logic                   grant;
   logic                   pop;
   logic                   fill;
   logic                   drop;
   logic                   rsp_used;
   logic [PTR_W-1:0]       fill_idx;
   logic [SUM_W-1:0]       occupancy;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^redirect_addr[1:0];
   assign imem_addr        = pc;

   // Handshake decode; a slot freed by this cycle's pop may be re-requested.
   always_comb begin
      fill_idx    = tail - PTR_W'(pend_cnt);
      fetch_valid = (count != '0) && q_filled[head];
      pop         = fetch_valid && !stall && !redirect;
      occupancy   = SUM_W'(count) + SUM_W'(discard_cnt) - SUM_W'(pop);
      imem_req    = !rst && !redirect && (occupancy < SUM_W'(QUEUE_DEPTH));
      grant       = imem_req && imem_gnt;
      drop        = imem_rvalid && (discard_cnt != '0);
      fill        = imem_rvalid && (discard_cnt == '0) && (pend_cnt != '0);
      rsp_used    = drop || fill;
   end

   always_comb begin
      instr                 = NOP;
      fetch_instr_addr      = '0;
      fetch_instr_addr_plus = '0;
      if (fetch_valid) begin
         instr                 = q_data[head];
         fetch_instr_addr      = q_addr[head];
         fetch_instr_addr_plus = q_addr[head] + 32'd4;
      end
   end

   // Control state; redirect wins over grant, pop and stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         pend_cnt    <= '0;
         discard_cnt <= '0;
         q_filled    <= '0;
      end else if (redirect) begin
         pc          <= {redirect_addr[31:2], 2'b00};
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         pend_cnt    <= '0;
         discard_cnt <= discard_cnt + pend_cnt - CNT_W'(rsp_used);
         q_filled    <= '0;
      end else begin
         if (grant) begin
            pc             <= pc + 32'd4;
            tail           <= tail + PTR_W'(1);
            q_filled[tail] <= 1'b0;
         end
         if (fill) begin
            q_filled[fill_idx] <= 1'b1;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (drop) begin
            discard_cnt <= discard_cnt - CNT_W'(1);
         end
         count    <= count + CNT_W'(grant) - CNT_W'(pop);
         pend_cnt <= pend_cnt + CNT_W'(grant) - CNT_W'(fill);
      end
   end

   // Payload storage needs no reset; q_filled and count qualify it.
   always_ff @(posedge clk) begin
      if (grant) begin
         q_addr[tail] <= pc;
      end
      if (fill) begin
         q_data[fill_idx] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: directed stimulus pushes hand-computed
// expectations, a monitor checks every instruction handed to decode.
module tb_stage_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] plus;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        stall;
   logic        fetch_valid;
   logic [31:0] instr;
   logic [31:0] fetch_instr_addr;
   logic [31:0] fetch_instr_addr_plus;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        gnt_en;
   logic        resp_en;
   logic [31:0] stop_addr;
   logic        gnt_prev = 1'b0;
   logic        rv_prev  = 1'b0;
   logic [31:0] addr_prev = 32'h0;
   exp_t        mon_e;

   stage_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .imem_req              (imem_req),
      .imem_addr             (imem_addr),
      .imem_gnt              (imem_gnt),
      .imem_rvalid           (imem_rvalid),
      .imem_rdata            (imem_rdata),
      .redirect              (redirect),
      .redirect_addr         (redirect_addr),
      .stall                 (stall),
      .fetch_valid           (fetch_valid),
      .instr                 (instr),
      .fetch_instr_addr      (fetch_instr_addr),
      .fetch_instr_addr_plus (fetch_instr_addr_plus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] p);
      exp_t e;
      e.instr = i;
      e.addr  = a;
      e.plus  = p;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en, input logic rsp, input logic [31:0] stop);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      redirect  = 1'b0;
      stall     = 1'b0;
      gnt_en    = en;
      resp_en   = rsp;
      stop_addr = stop;
      cyc(4);
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_left", 32'(exp_q.size()), 32'h0);
      repeat (3) @(negedge clk);
   endtask

   // Memory model: grants answered in order, one cycle later, data = addr|1.
   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         if (rv_prev && mem_q.size() > 0) void'(mem_q.pop_front());
         if (gnt_prev) mem_q.push_back(addr_prev);
         imem_gnt    = gnt_en && (imem_addr != stop_addr);
         imem_rvalid = resp_en && (mem_q.size() > 0);
         imem_rdata  = imem_rvalid ? (mem_q[0] | 32'h1) : 32'h0;
         rv_prev     = imem_rvalid;
         gnt_prev    = imem_req && imem_gnt;
         addr_prev   = imem_addr;
      end
   end

   // Monitor: every accepted instruction must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (fetch_valid && !stall && !redirect) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_pop: got addr %h instr %h, required no output",
                           fetch_instr_addr, instr);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("pop_instr", instr, mon_e.instr);
                  chk("pop_addr", fetch_instr_addr, mon_e.addr);
                  chk("pop_addr_plus", fetch_instr_addr_plus, mon_e.plus);
               end
            end else if (!fetch_valid) begin
               chk("idle_instr", instr, NOP);
               chk("idle_addr", fetch_instr_addr, 32'h0);
               chk("idle_addr_plus", fetch_instr_addr_plus, 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      redirect      = 1'b0;
      redirect_addr = 32'h0;
      stall         = 1'b0;
      gnt_en        = 1'b0;
      resp_en       = 1'b1;
      stop_addr     = 32'h0;
      #2;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(fetch_valid), 32'h0);
      chk("rst_instr", instr, NOP);
      chk("rst_addr", fetch_instr_addr, 32'h0);
      chk("rst_addr_plus", fetch_instr_addr_plus, 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);

      // Streaming from reset, then a 3-cycle stall with the queue full.
      do_reset(1'b1, 1'b1, 32'h20);
      for (int i = 0; i < 8; i++) push(32'(4 * i) | 32'h1, 32'(4 * i), 32'(4 * i + 4));
      @(negedge clk);
      chk("c0_imem_addr", imem_addr, 32'h0);
      chk("c0_req", 32'(imem_req), 32'h1);
      chk("c0_valid", 32'(fetch_valid), 32'h0);
      cyc(1);
      @(negedge clk);
      chk("c1_imem_addr", imem_addr, 32'h4);
      chk("c1_valid", 32'(fetch_valid), 32'h0);
      cyc(1);
      @(negedge clk);
      chk("c2_imem_addr", imem_addr, 32'h8);
      chk("c2_valid", 32'(fetch_valid), 32'h1);
      cyc(1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_req", 32'(imem_req), 32'h0);
         chk("stall_valid", 32'(fetch_valid), 32'h1);
         chk("stall_instr", instr, 32'h5);
         chk("stall_addr", fetch_instr_addr, 32'h4);
         cyc(1);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("resume_imem_addr", imem_addr, 32'hC);
      wait_drain();
      chk("stop_imem_addr", imem_addr, 32'h20);

      // Redirect with two grants outstanding at 0x10 and 0x14.
      do_reset(1'b0, 1'b0, 32'h0);
      redirect      = 1'b1;
      redirect_addr = 32'h10;
      @(negedge clk);
      chk("b_redir1_req", 32'(imem_req), 32'h0);
      cyc(1);
      redirect  = 1'b0;
      gnt_en    = 1'b1;
      stop_addr = 32'h18;
      cyc(2);
      @(negedge clk);
      chk("b_full_req", 32'(imem_req), 32'h0);
      chk("b_full_imem_addr", imem_addr, 32'h18);
      cyc(1);
      redirect      = 1'b1;
      redirect_addr = 32'h103;
      stop_addr     = 32'h110;
      @(negedge clk);
      chk("b_redir2_req", 32'(imem_req), 32'h0);
      cyc(1);
      redirect = 1'b0;
      @(negedge clk);
      chk("b_redir2_imem_addr", imem_addr, 32'h100);
      chk("b_discard_hold_req", 32'(imem_req), 32'h0);
      cyc(1);
      resp_en = 1'b1;
      push(32'h101, 32'h100, 32'h104);
      push(32'h105, 32'h104, 32'h108);
      push(32'h109, 32'h108, 32'h10C);
      push(32'h10D, 32'h10C, 32'h110);
      wait_drain();

      // Redirect coinciding with the response for the older of two outstanding.
      do_reset(1'b1, 1'b0, 32'h8);
      cyc(2);
      redirect      = 1'b1;
      redirect_addr = 32'h40;
      resp_en       = 1'b1;
      stop_addr     = 32'h48;
      @(negedge clk);
      chk("c_redir_req", 32'(imem_req), 32'h0);
      chk("c_rvalid_seen", 32'(imem_rvalid), 32'h1);
      cyc(1);
      redirect = 1'b0;
      @(negedge clk);
      chk("c_imem_addr", imem_addr, 32'h40);
      chk("c_req_one_owed", 32'(imem_req), 32'h1);
      push(32'h41, 32'h40, 32'h44);
      push(32'h45, 32'h44, 32'h48);
      wait_drain();

      // Asynchronous reset with two fetches outstanding; stragglers ignored.
      do_reset(1'b1, 1'b0, 32'h8);
      cyc(2);
      @(negedge clk);
      chk("d_pre_imem_addr", imem_addr, 32'h8);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("d_rst_imem_addr", imem_addr, 32'h0);
      chk("d_rst_req", 32'(imem_req), 32'h0);
      chk("d_rst_valid", 32'(fetch_valid), 32'h0);
      chk("d_rst_instr", instr, NOP);
      chk("d_rst_addr", fetch_instr_addr, 32'h0);
      gnt_en  = 1'b0;
      resp_en = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(2);
      @(negedge clk);
      chk("d_straggler_valid", 32'(fetch_valid), 32'h0);
      cyc(1);
      redirect      = 1'b1;
      redirect_addr = 32'h200;
      cyc(1);
      redirect  = 1'b0;
      gnt_en    = 1'b1;
      stop_addr = 32'h208;
      push(32'h201, 32'h200, 32'h204);
      push(32'h205, 32'h204, 32'h208);
      wait_drain();

      // PC wrap at the top of the address space.
      do_reset(1'b0, 1'b1, 32'h0);
      redirect      = 1'b1;
      redirect_addr = 32'hFFFF_FFFC;
      cyc(1);
      redirect  = 1'b0;
      gnt_en    = 1'b1;
      stop_addr = 32'h8;
      @(negedge clk);
      chk("e_imem_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(1);
      @(negedge clk);
      chk("e_wrap_imem_addr", imem_addr, 32'h0);
      push(32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0);
      push(32'h1, 32'h0, 32'h4);
      push(32'h5, 32'h4, 32'h8);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
